// File: rtl/div_bcd_out.sv
// Output stage of the 32/16 restoring divider: latches quotient/remainder on a rising
// ready level and converts the quotient to packed BCD with a one-bit-per-clock double-dabble.
module div_bcd_out #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RW     = 16,
  parameter int unsigned DIGITS = 10,
  parameter int unsigned CW     = 6
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin_q,
  input  logic [RW-1:0]         bin_r,
  output logic [4*DIGITS-1:0]   bcd_q,
  output logic [RW-1:0]         r_out,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         count
);

  localparam int unsigned AW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             load_d;
  logic [WIDTH-1:0] sh;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    adj;
  logic [AW-1:0]    acc_next;
  logic             req;
  logic             last;
  logic             accept;
  logic             shift_en;
  logic             finish;

  // Only a rising ready level is a request, so a held-high ready gives one conversion.
  assign req  = load & ~load_d;
  assign last = (count == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req)  next_state = SHIFT;
      SHIFT:   if (last) next_state = DONE;
      DONE:    if (req)  next_state = SHIFT;
      default: next_state = IDLE;
    endcase
  end

  // Control decode; requests arriving during SHIFT are dropped
  always_comb begin
    accept   = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE, DONE: accept = req;
      SHIFT: begin
        shift_en = 1'b1;
        finish   = last;
      end
      default: ;
    endcase
  end

  // Add-3 to every digit >= 5, then shift the next quotient bit into the bottom
  always_comb begin
    adj = acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = {adj[AW-2:0], sh[WIDTH-1]};
  end

  // Datapath and registered status
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      load_d <= 1'b0;
      sh     <= '0;
      acc    <= '0;
      bcd_q  <= '0;
      r_out  <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      load_d <= load;
      busy   <= (next_state == SHIFT);
      done   <= (next_state == DONE);
      if (accept) begin
        sh    <= bin_q;
        acc   <= '0;
        r_out <= bin_r;
        count <= '0;
      end else if (shift_en) begin
        acc   <= acc_next;
        sh    <= {sh[WIDTH-2:0], 1'b0};
        count <= count + CW'(1);
        if (finish) bcd_q <= acc_next;
      end
    end
  end

endmodule
